// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Bursts end on packet last, MAX_BURST beats, or owner going idle.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       wr_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  input  logic                       fifo_wr_error,
  output logic [WIDTH-1:0]           fifo_wdata,
  output logic                       fifo_wr_en,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       busy,
  output logic [7:0]                 err_count
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_d;
  logic [OW-1:0] rr_ptr;
  logic [OW-1:0] next_ptr;
  logic [BW-1:0] beat_cnt;

  logic [OW-1:0] pick;
  logic [OW-1:0] idx;
  logic          pick_valid;
  logic          in_burst;
  logic          own_valid;
  logic          own_last;
  logic          xfer;
  logic          burst_end;

  // Scan downwards so the last hit is the first index at/after rr_ptr
  always_comb begin
    pick_valid = 1'b0;
    pick       = rr_ptr;
    idx        = rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = OW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    in_burst  = (state == BURST) && !reset;
    own_valid = req_valid[owner];
    own_last  = req_last[owner];
    xfer      = in_burst && own_valid && !fifo_full;

    req_ready = '0;
    if (in_burst && !fifo_full)
      req_ready[owner] = 1'b1;

    fifo_wr_en = xfer;
    fifo_wdata = '0;
    if (xfer)
      fifo_wdata = req_data[int'(owner)*WIDTH +: WIDTH];

    busy = in_burst;

    burst_end = in_burst &&
      ((xfer && (own_last || beat_cnt == BW'(MAX_BURST - 1))) ||
       (!own_valid && !fifo_full));

    next_ptr = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (pick_valid) state_d = BURST;
      BURST: if (burst_end)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && pick_valid) begin
        owner    <= pick;
        beat_cnt <= '0;
      end
      if (xfer)
        beat_cnt <= beat_cnt + 1'b1;
      if (burst_end)
        rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset)
      err_count <= '0;
    else if (fifo_wr_error && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter sitting in the write-clock domain in front of `async_fifo`. Shares the FIFO's single write port (`wdata`/`wr_en`) among NUM_REQ requesters using bursts bounded by packet end or MAX_BURST beats. Never writes while the FIFO reports full. Counts FIFO write errors for debug.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 8, data width; matches FIFO WIDTH
- MAX_BURST, 4, maximum beats per grant (1..16)
- wr_clk  in  1  FIFO write clock; all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*WIDTH  requester i data at [i*WIDTH +: WIDTH]
- req_last  in  NUM_REQ  beat is last of packet; sampled only on transfer
- req_ready  out  NUM_REQ  one-hot-or-zero; beat accepted when valid & ready
- fifo_full  in  1  FIFO `full`
- fifo_wr_error  in  1  FIFO `wr_error`
- fifo_wdata  out  WIDTH  to FIFO `wdata`
- fifo_wr_en  out  1  to FIFO `wr_en`
- owner  out  clog2(NUM_REQ)  current or last granted requester
- busy  out  1  high in BURST
- err_count  out  8  saturating count of fifo_wr_error cycles

## Operation
- State: `IDLE`, `BURST`. Registers: state, owner, rr_ptr, beat_cnt (clog2(MAX_BURST)+1 bits), err_count.
- IDLE: if any req_valid, pick the first valid index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ. Next edge: state=BURST, owner=pick, beat_cnt=0. No valid: stay.
- BURST: req_ready[owner] = ~fifo_full; all other ready bits 0. Transfer = req_valid[owner] & req_ready[owner].
- fifo_wr_en = transfer (combinational). fifo_wdata = req_data[owner] when transfer, else 0.
- On transfer: beat_cnt += 1. Burst ends if req_last[owner]=1 or beat_cnt == MAX_BURST-1.
- Burst also ends when req_valid[owner]=0 and fifo_full=0 (owner idle release, no write that cycle).
- fifo_full=1 with owner valid: hold BURST, no beat counted, no release.
- On burst end: next edge state=IDLE, rr_ptr = (owner+1) mod NUM_REQ; owner holds its value.
- err_count increments on every cycle fifo_wr_error=1; saturates at 255; independent of FSM.
- Data is never dropped or duplicated. Order within one requester is preserved.

## Timing
- Reset (sync): next edge state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, err_count=0. Outputs req_ready=0, fifo_wr_en=0, fifo_wdata=0, busy=0.
- Reset mid-burst: any in-flight grant is abandoned. No write in the cycle reset is sampled high (outputs forced 0 while reset=1).
- Grant latency: req_valid rising in IDLE at edge k gives busy=1 and the first possible write in cycle k+1.
- One IDLE bubble after every burst. Peak throughput is MAX_BURST/(MAX_BURST+1) beats per cycle.
- fifo_full is used in the same cycle. A cycle with full=1 always has fifo_wr_en=0.
- A requester that loses arbitration keeps valid asserted. Fairness: a continuously valid requester waits at most (NUM_REQ-1) bursts.

## Test plan
- Single requester 0 sends 3 beats 0xA1,0xA2,0xA3 (last on 0xA3) → FIFO receives the 3 bytes on consecutive wr_clk cycles starting 1 cycle after valid; then IDLE, rr_ptr=1.
- Requesters 0 and 2 both continuously valid, 8-beat packets, MAX_BURST=4 → grants alternate 0,2,0,2 with 4 beats each and one bubble between bursts; no beat lost; per-source order intact.
- Requester 1 mid-burst with fifo_full forced high for 5 cycles → fifo_wr_en=0 and req_ready=0 throughout; beat_cnt frozen; transfer resumes with the same pending byte when full drops.
- Owner deasserts valid after 2 of 4 beats → burst releases; next valid requester is granted after the bubble; fill the FIFO to DEPTH=16 and confirm the FIFO's wr_error never asserts.
- Drive fifo_wr_error high for 300 cycles → err_count reads 255 and holds.
- Assert reset for 1 cycle during beat 2 of a burst → next cycle all outputs 0 and err_count=0; a fresh request is granted to the lowest valid index.
